// File: rtl/jtag_shift_seq.sv
// jtag_shift_seq: JTAG master sequencer for a single 1149.1 TAP.
// Takes one IR or DR shift command at a time. It generates TCK/TMS/TDI from
// CLK, captures TDO into RSP_DATA, and always returns the TAP to Run_Test_Idle.
// Optional build macro: JTAG_SEQ_TLR_PREAMBLE_EN. When it is defined, every
// command first forces the TAP through Test_Logic_Reset back to Run_Test_Idle.
module jtag_shift_seq #(
  parameter  int MAX_LEN = 32,
  parameter  int TCK_DIV = 4,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VLD,
  output logic               CMD_RDY,
  input  logic               CMD_IR,
  input  logic [LW-1:0]      CMD_LEN,
  input  logic [MAX_LEN-1:0] CMD_DATA,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               RSP_VLD,
  output logic [MAX_LEN-1:0] RSP_DATA,
  output logic               BUSY
);

  // Phase counter spans one full TCK period: low phase, then high phase.
  localparam int          PW      = $clog2(2 * TCK_DIV);
  localparam logic [PW-1:0] PH_RISE = PW'(TCK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_DIV - 1);

  typedef enum logic [2:0] {
    ST_INIT,   // 5x TMS=1 then TMS=0: Test_Logic_Reset, then Run_Test_Idle
    ST_IDLE,   // waiting for a command, TAP parked in Run_Test_Idle
    ST_PRE,    // optional forced Test_Logic_Reset before each command
    ST_HEAD,   // walk from Run_Test_Idle into Shift-DR / Shift-IR
    ST_SHIFT,  // one TCK period per data bit
    ST_TAIL,   // Exit1 -> Update -> Run_Test_Idle
    ST_DONE    // trailing TCK fall, then the response pulse
  } state_t;

  state_t             state;
  state_t             state_after;
  logic [PW-1:0]      ph;
  logic [2:0]         step;
  logic [LW-1:0]      bit_cnt;
  logic               ir_q;
  logic [MAX_LEN-1:0] sh_q;
  logic [MAX_LEN-1:0] mask_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               period_tms;
  logic               period_tdi;
  logic               last_period;
  logic               len_ok;

  assign BUSY   = ~CMD_RDY;
  assign len_ok = (CMD_LEN != '0) && (CMD_LEN <= LW'(MAX_LEN));

  // TMS/TDI for the current TCK period, and whether it is the state's last period.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    period_tms  = 1'b0;
    period_tdi  = 1'b0;
    last_period = 1'b0;
    state_after = ST_IDLE;
    case (state)
      ST_INIT, ST_PRE: begin
        period_tms  = (step != 3'd5);
        last_period = (step == 3'd5);
        state_after = (state == ST_PRE) ? ST_HEAD : ST_IDLE;
      end
      ST_HEAD: begin
        period_tms  = (step == 3'd0) || (ir_q && (step == 3'd1));
        last_period = ir_q ? (step == 3'd3) : (step == 3'd2);
        state_after = ST_SHIFT;
      end
      ST_SHIFT: begin
        period_tms  = (bit_cnt == '0);
        period_tdi  = sh_q[0];
        last_period = (bit_cnt == '0);
        state_after = ST_TAIL;
      end
      ST_TAIL: begin
        period_tms  = (step == 3'd0);
        last_period = (step == 3'd1);
        state_after = ST_DONE;
      end
      default: ;
    endcase
  end

  // Sequencer FSM and TCK period engine, all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_INIT;
      ph       <= '0;
      step     <= '0;
      bit_cnt  <= '0;
      ir_q     <= 1'b0;
      // NOTE: the data registers are reset as well, because RSP_DATA must read
      // 0 straight out of reset and a stale capture must never leak out.
      sh_q     <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      TCK      <= 1'b0;
      TMS      <= 1'b1;
      TDI      <= 1'b0;
      CMD_RDY  <= 1'b0;
      RSP_VLD  <= 1'b0;
      RSP_DATA <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only. Every read
      // in this block therefore sees the value from before this edge.
      RSP_VLD <= 1'b0;
      case (state)
        ST_IDLE: begin
          TCK     <= 1'b0;
          CMD_RDY <= 1'b1;
          if (CMD_VLD && CMD_RDY) begin
            CMD_RDY <= 1'b0;
            ir_q    <= CMD_IR;
            bit_cnt <= CMD_LEN - LW'(1);
            sh_q    <= CMD_DATA;
            mask_q  <= MAX_LEN'(1);
            cap_q   <= '0;
            ph      <= '0;
            step    <= '0;
            if (!len_ok) begin
              state <= ST_DONE;
            end else begin
`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
              state <= ST_PRE;
`else
              state <= ST_HEAD;
`endif
            end
          end
        end
        ST_DONE: begin
          TCK <= 1'b0;
          TDI <= 1'b0;
          if (ph == '0) begin
            ph <= PW'(1);
          end else begin
            ph       <= '0;
            RSP_VLD  <= 1'b1;
            RSP_DATA <= cap_q;
            CMD_RDY  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          // Start of the low phase: TCK falls and TMS/TDI change together.
          if (ph == '0) begin
            TCK <= 1'b0;
            TMS <= period_tms;
            TDI <= period_tdi;
          end
          // Start of the high phase: TCK rises; TDO is captured only while shifting.
          if (ph == PH_RISE) begin
            TCK <= 1'b1;
            if ((state == ST_SHIFT) && TDO) begin
              cap_q <= cap_q | mask_q;
            end
          end
          if (ph == PH_LAST) begin
            ph <= '0;
            if (state == ST_SHIFT) begin
              sh_q   <= sh_q >> 1;
              mask_q <= mask_q << 1;
            end
            if (last_period) begin
              step  <= '0;
              state <= state_after;
            end else if (state == ST_SHIFT) begin
              bit_cnt <= bit_cnt - LW'(1);
            end else begin
              step <= step + 3'd1;
            end
          end else begin
            ph <= ph + PW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_shift_seq.sv
// tb_jtag_shift_seq: bench for jtag_shift_seq with a behavioural 1149.1 TAP.
// Expected responses and due cycles go into a scoreboard when a command is
// accepted. They are compared when RSP_VLD pulses.
module tb_jtag_shift_seq;

  localparam int MAX_LEN = 32;
  localparam int TCK_DIV = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);
`ifdef JTAG_SEQ_TLR_PREAMBLE_EN
  localparam int PRE_PERIODS = 6;
`else
  localparam int PRE_PERIODS = 0;
`endif
  localparam logic [31:0] IR_CAPTURE = 32'h1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic CMD_VLD = 1'b0;
  logic CMD_IR = 1'b0;
  logic [LW-1:0] CMD_LEN = '0;
  logic [MAX_LEN-1:0] CMD_DATA = '0;
  logic CMD_RDY, TCK, TMS, TDI, TDO, RSP_VLD, BUSY;
  logic [MAX_LEN-1:0] RSP_DATA;

  jtag_shift_seq #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV)) dut (
    .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_IR(CMD_IR),
    .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR,
    TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
      default:    return tms ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction

  function automatic logic [31:0] len_mask(input int len);
    return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
  endfunction

  tap_t        tap_st = TAP_SH_DR;
  logic [31:0] tap_dr = '0;
  logic [31:0] tap_ir = '0;
  logic [31:0] tap_sh = '0;
  int          tap_dr_len = 8;
  int          tap_ir_len = 10;
  int          tdo_mode = 2;  // 0: tied low, 1: tied high, 2: from TAP model
  int          tck_rises = 0;
  int          shift_rises = 0;
  bit          tms_log[$];

  assign TDO = (tdo_mode == 2) ? (((tap_st == TAP_SH_DR) || (tap_st == TAP_SH_IR)) && tap_sh[0])
                               : (tdo_mode == 1);

  always @(posedge TCK) begin
    tck_rises++;
    tms_log.push_back(TMS);
    if (tap_st == TAP_SH_DR) shift_rises++;
    case (tap_st)
      TAP_CAP_DR: tap_sh <= tap_dr & len_mask(tap_dr_len);
      TAP_SH_DR:  tap_sh <= (tap_sh >> 1) | (32'(TDI) << (tap_dr_len - 1));
      TAP_UPD_DR: tap_dr <= tap_sh;
      TAP_CAP_IR: tap_sh <= IR_CAPTURE;
      TAP_SH_IR:  tap_sh <= (tap_sh >> 1) | (32'(TDI) << (tap_ir_len - 1));
      TAP_UPD_IR: tap_ir <= tap_sh;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, TMS);
  end

  // ---------------- expectations ----------------
  function automatic bit len_valid(input int len);
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

  function automatic int periods(input bit ir, input int len);
    if (!len_valid(len)) return 0;
    return PRE_PERIODS + (ir ? 4 : 3) + len + 2;
  endfunction

  function automatic int latency(input bit ir, input int len);
    if (!len_valid(len)) return 2;
    return (PRE_PERIODS + (ir ? 6 : 5) + len) * 2 * TCK_DIV + 2;
  endfunction

  function automatic logic [63:0] exp_tms(input bit ir, input int len);
    logic [63:0] v = '0;
    int n = 0;
    if (!len_valid(len)) return v;
    for (int i = 0; i < PRE_PERIODS; i++) begin v[n] = (i < 5); n++; end
    v[n] = 1'b1; n++;
    if (ir) begin v[n] = 1'b1; n++; end
    n += 2;                       // Capture, then enter Shift, both TMS=0
    n += len - 1;                 // all but the last bit have TMS=0
    v[n] = 1'b1; n++;             // last bit -> Exit1
    v[n] = 1'b1; n++;             // Update
    return v;                     // final RTI period is TMS=0
  endfunction

  function automatic logic [63:0] tms_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   rsp_cnt = 0;
  int   tck_base = 0;

  always @(negedge CLK) begin
    if (RSP_VLD) begin
      rsp_cnt++;
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_data", RSP_DATA, mon_e.data);
        check("rsp_latency_edge", cyc, mon_e.due);
      end
    end
  end

  // Call positioned just after a negedge; returns one negedge after accept.
  task automatic send(input bit ir, input int len, input logic [31:0] data,
                      input logic [31:0] exp_rsp, output int acc_edge);
    int budget = 0;
    CMD_VLD  = 1'b1;
    CMD_IR   = ir;
    CMD_LEN  = LW'(len);
    CMD_DATA = data;
    while (!CMD_RDY && budget < 3000) begin @(negedge CLK); budget++; end
    if (!CMD_RDY) check("accept_timeout", 64'd0, 64'd1);
    acc_edge = cyc + 1;
    sb_q.push_back('{exp_rsp, acc_edge + latency(ir, len)});
    tms_log.delete();
    tck_base = tck_rises;
    @(negedge CLK);
    check("rdy_drop_after_accept", {CMD_RDY, BUSY}, 2'b01);
  endtask

  task automatic wait_rsp(input string tag);
    int budget = 0;
    while (sb_q.size() != 0 && budget < 3000) begin @(negedge CLK); budget++; end
    if (sb_q.size() != 0) begin
      check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
      sb_q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic do_cmd(input string tag, input bit ir, input int len,
                        input logic [31:0] data, input logic [31:0] exp_rsp);
    int acc;
    send(ir, len, data, exp_rsp, acc);
    CMD_VLD = 1'b0;
    wait_rsp(tag);
    check({tag, "_tck_periods"}, tck_rises - tck_base, periods(ir, len));
    check({tag, "_tms_seq"}, tms_vec(), exp_tms(ir, len));
    check({tag, "_tap_rti"}, tap_st, TAP_RTI);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tck"}, TCK, 1'b0);
    check({tag, "_tms"}, TMS, 1'b1);
    check({tag, "_tdi"}, TDI, 1'b0);
    check({tag, "_cmd_rdy"}, CMD_RDY, 1'b0);
    check({tag, "_busy"}, BUSY, 1'b1);
    check({tag, "_rsp_vld"}, RSP_VLD, 1'b0);
    check({tag, "_rsp_data"}, RSP_DATA, 32'h0);
  endtask

  task automatic release_and_check_init(input string tag);
    int c0;
    int budget = 0;
    @(negedge CLK);
    tms_log.delete();
    tck_base = tck_rises;
    RST = 1'b0;
    c0 = cyc;
    while (!CMD_RDY && budget < 200) begin @(negedge CLK); budget++; end
    check({tag, "_rdy_rise_edge"}, cyc - c0, 49);
    check({tag, "_tck_periods"}, tck_rises - tck_base, 6);
    check({tag, "_tms_seq"}, tms_vec(), 64'h1F);
    check({tag, "_tap_rti"}, tap_st, TAP_RTI);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, t0, r0, budget, base;
    logic [31:0] d, old;

    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");

    // Reset release: INIT walks the TAP from Shift-DR to RTI.
    release_and_check_init("init");

    // DR scan with TDO looped through the TAP data register.
    tdo_mode = 2; tap_dr_len = 8; tap_dr = 32'h5A;
    do_cmd("dr8", 1'b0, 8, 32'hA5, 32'h5A);
    check("dr8_tap_dr", tap_dr, 32'hA5);

    // IR scan.
    tap_ir_len = 10;
    do_cmd("ir10", 1'b1, 10, 32'h3C2, IR_CAPTURE & len_mask(10));
    check("ir10_tap_ir", tap_ir, 32'h3C2);

    // Odd-length DR scan with random data; bits above LEN must read 0.
    tap_dr_len = 13;
    old = $urandom() & len_mask(13);
    d   = $urandom();
    tap_dr = old;
    do_cmd("dr13", 1'b0, 13, d, old);
    check("dr13_tap_dr", tap_dr, d & len_mask(13));

    // Full-length scans with TDO tied low, then high.
    tap_dr_len = 32;
    tdo_mode = 0;
    do_cmd("dr32_tdo0", 1'b0, 32, 32'hFFFF_FFFF, 32'h0);
    tdo_mode = 1;
    do_cmd("dr32_tdo1", 1'b0, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tdo_mode = 2;

    // Zero-length commands back to back with CMD_VLD held high.
    t0 = tck_rises;
    send(1'b0, 0, 32'h1234_5678, 32'h0, acc1);
    send(1'b1, 0, 32'h8765_4321, 32'h0, acc2);
    CMD_VLD = 1'b0;
    wait_rsp("len0_pair");
    check("len0_back_to_back_accept_gap", acc2 - acc1, 3);
    check("len0_no_tck", tck_rises - t0, 0);

    // Over-length command behaves like LEN=0.
    do_cmd("len33", 1'b0, 33, 32'hDEAD_BEEF, 32'h0);

    // Reset during SHIFT bit 5 aborts the command.
    tap_dr_len = 8; tap_dr = 32'h5A;
    send(1'b0, 8, 32'hA5, 32'h5A, acc1);
    CMD_VLD = 1'b0;
    base = shift_rises;
    budget = 0;
    while ((shift_rises - base) < 5 && budget < 2000) begin @(negedge CLK); budget++; end
    repeat (TCK_DIV + 1) @(negedge CLK);
    check("abort_in_shift_bit5", shift_rises - base, 5);
    #1 RST = 1'b1;
    #1 check_reset_vals("abort");
    check("abort_pending_rsp", sb_q.size(), 1);
    sb_q.delete();
    r0 = rsp_cnt;
    repeat (3) @(negedge CLK);
    release_and_check_init("reinit");
    check("abort_no_rsp", rsp_cnt, r0);

    // Normal operation after the abort.
    tap_dr = 32'h33;
    do_cmd("dr8_again", 1'b0, 8, 32'hC3, 32'h33);
    check("dr8_again_tap_dr", tap_dr, 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
